// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit with lane-aligned byte enables, a valid/ready
//            memory port with timeout, and sign/zero-extended load return.
//            Optional macro LSU_MISALIGN_TRAP_EN: report misaligned accesses
//            (cause 1) instead of aligning them down to the access size.
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    // core request
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    // core response
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic [1:0]          resp_cause,
    // memory port
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int          c_NB         = XLEN / 8;
    localparam int          c_LG         = $clog2(c_NB);
    localparam logic [1:0]  c_CAUSE_NONE = 2'd0;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic [1:0]  c_CAUSE_MIS  = 2'd1;
`endif
    localparam logic [1:0]  c_CAUSE_ILL  = 2'd2;
    localparam logic [1:0]  c_CAUSE_TMO  = 2'd3;
    localparam logic [15:0] c_TMO_LAST   = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [c_LG-1:0]     r_off;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_NB-1:0]     r_be;
    logic [XLEN-1:0]     r_wdata;
    logic [1:0]          r_cause;
    logic [XLEN-1:0]     r_rdata;
    logic [15:0]         r_cnt;

    logic [3:0]          w_szmask;
    logic [c_LG-1:0]     w_off;
    logic [c_NB-1:0]     w_be;
    logic [XLEN-1:0]     w_wdata;
    logic                w_illegal;
    logic [1:0]          w_err_cause;
    logic                w_tmo;
    logic [XLEN-1:0]     w_shift;
    logic [XLEN-1:0]     w_ld_mask;
    logic                w_ld_sign;
    logic [XLEN-1:0]     w_ld_data;

    // ------------------------------------------------------------------
    // Request decode: lane offset, byte enables, shifted store data
    // ------------------------------------------------------------------
    assign w_szmask  = 4'((4'd1 << req_size) - 4'd1);
    assign w_illegal = (int'(req_size) > c_LG);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misal;
    assign w_misal     = |(req_addr[c_LG-1:0] & w_szmask[c_LG-1:0]);
    assign w_off       = req_addr[c_LG-1:0];
    assign w_err_cause = w_illegal ? c_CAUSE_ILL :
                         w_misal   ? c_CAUSE_MIS : c_CAUSE_NONE;
`else
    // Without the trap, misaligned addresses are rounded down to the access size.
    assign w_off       = req_addr[c_LG-1:0] & ~w_szmask[c_LG-1:0];
    assign w_err_cause = w_illegal ? c_CAUSE_ILL : c_CAUSE_NONE;
`endif

    always_comb begin
        w_be = '0;
        for (int i = 0; i < c_NB; i++) begin
            w_be[i] = (i >= int'(w_off)) &&
                      (i < int'(w_off) + int'(32'd1 << req_size));
        end
    end

    assign w_wdata = req_wdata << {w_off, 3'b000};

    // ------------------------------------------------------------------
    // Load return: shift lane down, truncate, then extend
    // ------------------------------------------------------------------
    assign w_shift = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ld_mask = '0;
        w_ld_sign = 1'b0;
        for (int i = 0; i < c_NB; i++) begin
            if (i < int'(32'd1 << r_size)) begin
                w_ld_mask[8*i +: 8] = 8'hFF;
            end
            if (i == int'(32'd1 << r_size) - 1) begin
                w_ld_sign = w_shift[8*i+7];
            end
        end
        // A full-width load has an all-ones mask, so the extension term vanishes.
        w_ld_data = (w_shift & w_ld_mask) |
                    ((w_ld_sign && !r_unsigned) ? ~w_ld_mask : '0);
    end

    assign w_tmo = (r_cnt >= c_TMO_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = (w_err_cause != c_CAUSE_NONE) ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                // A handshake in the final budget cycle still proceeds to WAIT.
                if (mem_ready) begin
                    w_next = S_WAIT;
                end else if (w_tmo) begin
                    w_next = S_RESP;
                end
            end
            S_WAIT: begin
                if (mem_rvalid || w_tmo) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request / response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_off      <= '0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_cause    <= c_CAUSE_NONE;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= w_off;
                        r_addr     <= {req_addr[ADDR_W-1:c_LG], {c_LG{1'b0}}};
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        r_cause    <= w_err_cause;
                        r_rdata    <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (!mem_ready && w_tmo) begin
                        r_cause <= c_CAUSE_TMO;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (mem_rvalid) begin
                        r_rdata <= r_we ? '0 : w_ld_data;
                    end else if (w_tmo) begin
                        r_cause <= c_CAUSE_TMO;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs; handshakes are masked during reset so an abort is immediate
    // ------------------------------------------------------------------
    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign mem_valid  = (r_state == S_REQ)  && !rst;
    assign resp_valid = (r_state == S_RESP) && !rst;

    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_be     = r_be;
    assign mem_wdata  = r_wdata;

    assign resp_err   = resp_valid && (r_cause != c_CAUSE_NONE);
    assign resp_cause = resp_valid ? r_cause : c_CAUSE_NONE;
    assign resp_rdata = resp_valid ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// tb_lsu: scoreboard bench for lsu (XLEN=32, TIMEOUT_CYC=8) with a
// variable-latency memory model; expectations are hand-computed vectors.
module tb_lsu;

    localparam int XLEN = 32;
    localparam int AW   = 32;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [1:0]      req_size = 2'd0;
    logic            req_unsigned = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic [1:0]      resp_cause;
    logic            mem_valid;
    logic            mem_ready = 1'b0;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;

    lsu #(.XLEN(XLEN), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_cause(resp_cause),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        err;
        logic [1:0]  cause;
        logic [31:0] rdata;
        int          at;
    } resp_exp_t;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    resp_exp_t sb[$];
    mem_exp_t  mq[$];

    // memory model configuration (written by stimulus only)
    int          ready_delay = 0;
    int          rv_delay    = 1;
    logic        never_ready = 1'b0;
    logic [31:0] rd_val      = '0;
    int          stray_at    = -1;

    function automatic logic [31:0] bytemask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // ---------------- response monitor ----------------
    resp_exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got err=%0b cause=%0d rdata=%h at cyc %0d, required no response",
                         resp_err, resp_cause, resp_rdata, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (resp_err !== mon_e.err || resp_cause !== mon_e.cause ||
                    resp_rdata !== mon_e.rdata || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL %s: got err=%0b cause=%0d rdata=%h cyc=%0d, required err=%0b cause=%0d rdata=%h cyc=%0d",
                             mon_e.name, resp_err, resp_cause, resp_rdata, cyc,
                             mon_e.err, mon_e.cause, mon_e.rdata, mon_e.at);
                end
            end
        end
    end

    // ---------------- memory model ----------------
    int          wait_cnt = 0;
    int          rv_left = 0;
    int          run = 0;
    int          last_run = 0;
    int          valid_cycles = 0;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    mem_exp_t    me;

    always @(negedge clk) begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        if (rst) begin
            wait_cnt = 0;
            rv_left  = 0;
            run      = 0;
        end else begin
            if (rv_left > 0) begin
                rv_left--;
                if (rv_left == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_val;
                end
            end
            if (stray_at == cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0_BAD0;
            end
            if (mem_valid) begin
                valid_cycles++;
                if (run == 0) begin
                    h_we = mem_we; h_addr = mem_addr; h_be = mem_be; h_wdata = mem_wdata;
                end else begin
                    checks++;
                    if (mem_we !== h_we || mem_addr !== h_addr || mem_be !== h_be || mem_wdata !== h_wdata) begin
                        errors++;
                        $display("FAIL mem_stable: got we=%0b addr=%h be=%b wdata=%h, required we=%0b addr=%h be=%b wdata=%h",
                                 mem_we, mem_addr, mem_be, mem_wdata, h_we, h_addr, h_be, h_wdata);
                    end
                end
                run++;
                if (!never_ready && wait_cnt >= ready_delay) begin
                    mem_ready = 1'b1;
                    rv_left   = rv_delay;
                    wait_cnt  = 0;
                    checks++;
                    if (mq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_mem_req: got addr=%h be=%b, required no memory access", mem_addr, mem_be);
                    end else begin
                        me = mq.pop_front();
                        if (mem_we !== me.we || mem_addr !== me.addr || mem_be !== me.be ||
                            (me.we && ((mem_wdata & bytemask(me.be)) !== (me.wdata & bytemask(me.be))))) begin
                            errors++;
                            $display("FAIL %s_mem: got we=%0b addr=%h be=%b wdata=%h, required we=%0b addr=%h be=%b wdata=%h",
                                     me.name, mem_we, mem_addr, mem_be, mem_wdata, me.we, me.addr, me.be, me.wdata);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                if (run != 0) last_run = run;
                run      = 0;
                wait_cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Called at negedge+1; lat=0 means no response is expected.
    task automatic op(input string name, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic err, input logic [1:0] cause, input logic [31:0] rdata, input int lat,
                      input logic has_mem, input logic [31:0] maddr, input logic [3:0] mbe,
                      input logic [31:0] mwdata, output int acc);
        resp_exp_t e;
        mem_exp_t  m;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk); #1;
        end
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL %s_accept: req_ready stayed 0, required 1 within 20 cycles", name);
        end else begin
            if (has_mem) begin
                m.name = name; m.we = we; m.addr = maddr; m.be = mbe; m.wdata = mwdata;
                mq.push_back(m);
            end
            if (lat > 0) begin
                e.name = name; e.err = err; e.cause = cause; e.rdata = rdata; e.at = acc + lat;
                sb.push_back(e);
            end
        end
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && mq.size() == 0) return;
            @(negedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL %s_drain: %0d responses and %0d memory requests outstanding, required 0",
                 name, sb.size(), mq.size());
        sb.delete();
        mq.delete();
    endtask

    // ---------------- directed sequence ----------------
    int a0, a1, a2, vc;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_valid",  {31'd0, mem_valid},  32'd0);
        chk("rst_mem_be",     {28'd0, mem_be},     32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // zero-wait store byte, then back-to-back load
        op("sb_1003", 1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, 1'b0, 2'd0, 32'h0, 3,
           1'b1, 32'h1000, 4'b1000, 32'hAB00_0000, a0);
        wait_idle("sb_1003");
        rd_val = 32'h8001_1234;
        op("lh_2002", 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 1'b0, 2'd0, 32'hFFFF_8001, 3,
           1'b1, 32'h2000, 4'b1100, 32'h0, a1);
        chk("b2b_accept_gap", a1 - a0, 32'd4);
        wait_idle("lh_2002");
        op("lhu_2002", 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 1'b0, 2'd0, 32'h0000_8001, 3,
           1'b1, 32'h2000, 4'b1100, 32'h0, a1);
        wait_idle("lhu_2002");

        rd_val = 32'h1234_F678;
        op("lb_1001", 1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 1'b0, 2'd0, 32'hFFFF_FFF6, 3,
           1'b1, 32'h1000, 4'b0010, 32'h0, a1);
        wait_idle("lb_1001");
        op("lbu_1001", 1'b0, 2'd0, 1'b1, 32'h1001, 32'h0, 1'b0, 2'd0, 32'h0000_00F6, 3,
           1'b1, 32'h1000, 4'b0010, 32'h0, a1);
        wait_idle("lbu_1001");

        rd_val = 32'hDEAD_BEEF;
        op("lw_4000", 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 1'b0, 2'd0, 32'hDEAD_BEEF, 3,
           1'b1, 32'h4000, 4'b1111, 32'h0, a1);
        wait_idle("lw_4000");
        op("sh_4002", 1'b1, 2'd1, 1'b0, 32'h4002, 32'h0000_BEEF, 1'b0, 2'd0, 32'h0, 3,
           1'b1, 32'h4000, 4'b1100, 32'hBEEF_0000, a1);
        wait_idle("sh_4002");
        op("sw_4008", 1'b1, 2'd2, 1'b0, 32'h4008, 32'h1122_3344, 1'b0, 2'd0, 32'h0, 3,
           1'b1, 32'h4008, 4'b1111, 32'h1122_3344, a1);
        wait_idle("sw_4008");

        // stalled memory: ready after 3 low cycles, data 2 cycles after handshake
        ready_delay = 3; rv_delay = 2; rd_val = 32'hCAFE_F00D;
        op("lw_stall", 1'b0, 2'd2, 1'b0, 32'h5004, 32'h0, 1'b0, 2'd0, 32'hCAFE_F00D, 7,
           1'b1, 32'h5004, 4'b1111, 32'h0, a1);
        wait_idle("lw_stall");
        chk("stall_valid_cycles", last_run, 32'd4);
        ready_delay = 0; rv_delay = 1;

        // illegal size: error at C1, ready again at C2, no memory access
        vc = valid_cycles;
        op("ld_illegal", 1'b0, 2'd3, 1'b0, 32'h6000, 32'h0, 1'b1, 2'd2, 32'h0, 1,
           1'b0, 32'h0, 4'b0, 32'h0, a2);
        wait_idle("ld_illegal");
        chk("illegal_no_mem", valid_cycles - vc, 32'd0);
        rd_val = 32'h0102_0304;
        op("lw_after_err", 1'b0, 2'd2, 1'b0, 32'h6004, 32'h0, 1'b0, 2'd0, 32'h0102_0304, 3,
           1'b1, 32'h6004, 4'b1111, 32'h0, a1);
        chk("err_accept_gap", a1 - a2, 32'd2);
        wait_idle("lw_after_err");

        // misaligned accesses
        vc = valid_cycles;
`ifdef LSU_MISALIGN_TRAP_EN
        op("lw_3001", 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 1'b1, 2'd1, 32'h0, 1,
           1'b0, 32'h0, 4'b0, 32'h0, a1);
        wait_idle("lw_3001");
        rd_val = 32'h8001_1234;
        op("lh_2003", 1'b0, 2'd1, 1'b0, 32'h2003, 32'h0, 1'b1, 2'd1, 32'h0, 1,
           1'b0, 32'h0, 4'b0, 32'h0, a1);
        wait_idle("lh_2003");
        chk("misal_no_mem", valid_cycles - vc, 32'd0);
`else
        op("lw_3001", 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 1'b0, 2'd0, 32'h0102_0304, 3,
           1'b1, 32'h3000, 4'b1111, 32'h0, a1);
        wait_idle("lw_3001");
        rd_val = 32'h8001_1234;
        op("lh_2003", 1'b0, 2'd1, 1'b0, 32'h2003, 32'h0, 1'b0, 2'd0, 32'hFFFF_8001, 3,
           1'b1, 32'h2000, 4'b1100, 32'h0, a1);
        wait_idle("lh_2003");
        chk("misal_mem_cycles", valid_cycles - vc, 32'd2);
`endif

        // timeout with memory never ready, stray rvalid at C12
        never_ready = 1'b1;
        op("lw_timeout", 1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 1'b1, 2'd3, 32'h0, TMO + 1,
           1'b0, 32'h0, 4'b0, 32'h0, a2);
        stray_at = a2 + 12;
        wait_idle("lw_timeout");
        chk("timeout_valid_cycles", last_run, TMO);
        never_ready = 1'b0; ready_delay = 2; rv_delay = 1; rd_val = 32'h600D_F00D;
        op("lw_after_tmo", 1'b0, 2'd2, 1'b0, 32'h7004, 32'h0, 1'b0, 2'd0, 32'h600D_F00D, 5,
           1'b1, 32'h7004, 4'b1111, 32'h0, a1);
        chk("tmo_accept_gap", a1 - a2, 32'd10);
        wait_idle("lw_after_tmo");
        stray_at = -1;

        // rvalid in the final budget cycle wins over the timeout
        ready_delay = 0; rv_delay = TMO - 1; rd_val = 32'h1234_5678;
        op("lw_tmo_edge", 1'b0, 2'd2, 1'b0, 32'h7008, 32'h0, 1'b0, 2'd0, 32'h1234_5678, TMO + 1,
           1'b1, 32'h7008, 4'b1111, 32'h0, a1);
        wait_idle("lw_tmo_edge");
        // one cycle later the budget is spent: timeout, late data ignored
        rv_delay = TMO;
        op("lw_tmo_late", 1'b0, 2'd2, 1'b0, 32'h700C, 32'h0, 1'b1, 2'd3, 32'h0, TMO + 1,
           1'b1, 32'h700C, 4'b1111, 32'h0, a1);
        wait_idle("lw_tmo_late");

        // reset while waiting for memory data
        rv_delay = 10;
        op("lw_rst", 1'b0, 2'd2, 1'b0, 32'h7100, 32'h0, 1'b0, 2'd0, 32'h0, 0,
           1'b1, 32'h7100, 4'b1111, 32'h0, a1);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_wait_mem_valid",  {31'd0, mem_valid},  32'd0);
        chk("rst_wait_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_wait_req_ready",  {31'd0, req_ready},  32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_wait_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (15) @(negedge clk);
        #1;

        rv_delay = 1; rd_val = 32'h7F00_0000;
        op("lb_7103", 1'b0, 2'd0, 1'b0, 32'h7103, 32'h0, 1'b0, 2'd0, 32'h0000_007F, 3,
           1'b1, 32'h7100, 4'b1000, 32'h0, a1);
        wait_idle("lb_7103");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Parametrised load/store unit sitting between the core datapath and data memory, replacing the combinational address/mask path around `data_mem`. It accepts one load or store at a time from the core and generates lane-aligned byte enables and write data. It drives a valid/ready memory port that may have variable latency, then returns sign- or zero-extended load data. It also reports misalignment, illegal size and memory timeout errors.

## Interface
- `XLEN`, 32, data width in bits; 32 or 64.
- `ADDR_W`, 32, byte address width.
- `TIMEOUT_CYC`, 64, maximum cycles spent in REQ+WAIT before a timeout error; range 2..65535.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: core request present.
- `req_ready` output 1: LSU can accept; high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 byte, 1 half, 2 word, 3 double.
- `req_unsigned` input 1: zero-extend load data (LBU/LHU/LWU).
- `req_addr` input ADDR_W: byte address (rs1 + imm).
- `req_wdata` input XLEN: store data, LSB-justified.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output XLEN: extended load data; 0 for stores and errors.
- `resp_err` output 1: error qualifier, valid with `resp_valid`.
- `resp_cause` output 2: 0 none, 1 misaligned, 2 illegal size, 3 timeout.
- `mem_valid` output 1: memory request.
- `mem_ready` input 1: memory accepts request.
- `mem_we` output 1: write request.
- `mem_addr` output ADDR_W: address aligned down to XLEN/8 bytes.
- `mem_be` output XLEN/8: byte enables.
- `mem_wdata` output XLEN: lane-shifted store data.
- `mem_rvalid` input 1: memory completion; ack for stores, data for loads.
- `mem_rdata` input XLEN: read data, full aligned word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on `req_valid && req_ready`, register the request and check it.
  - Illegal: `req_size` > log2(XLEN/8), e.g. size 3 with XLEN=32.
  - Misaligned: `req_addr mod 2^size != 0`.
  - Error request: go to RESP with the matching cause; no memory access is made.
  - Legal request: go to REQ.
- REQ: hold `mem_valid` and all `mem_*` fields stable until `mem_ready`, then go to WAIT.
- WAIT: sample `mem_rvalid` only in this state. When it is high, capture `mem_rdata` and go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE. There is no core backpressure.
- Byte lane and enables:
  - off = addr[log2(XLEN/8)-1:0].
  - `mem_be` = ((1<<2^size)-1) << off.
  - `mem_wdata` = `req_wdata` << (8*off); bytes outside the enables are don't-care.
- Loads:
  - Shift right: `mem_rdata` >> (8*off).
  - Truncate to 8·2^size bits.
  - Extend: sign-extend unless `req_unsigned` or size equals XLEN; otherwise zero-extend.
- Timeout:
  - Counter clears on accept and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYC`, drop `mem_valid`, go to RESP with cause 3.
  - A `mem_rvalid` arriving later, in IDLE or a later transaction's REQ, is ignored.
- Reset mid-operation: return to IDLE immediately and drop `mem_valid`. No `resp_valid` is produced for the aborted request.
- Reset values:
  - `req_ready`=0 while `rst`=1, 1 in the first cycle after reset.
  - All other outputs 0.

## Timing
- Accept cycle = C0; `mem_valid` rises in C1 (registered).
- Memory handshake at Ck moves the FSM to WAIT at Ck+1.
- `mem_rvalid` at Cm (m ≥ k+1) gives `resp_valid` at Cm+1.
- Zero-wait memory: load/store completes with `resp_valid` in C3; next request accepted in C4.
- Error detected at accept: `resp_valid` in C1; `req_ready` high again in C2.
- `mem_rvalid` coinciding with the handshake cycle is ignored. Memory must assert it no earlier than the cycle after `mem_ready`.
- Timeout with `mem_ready` stuck low: `resp_valid` at C(TIMEOUT_CYC+1).
- Timeout and `mem_rvalid` in the same cycle: completion wins, no error.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses report cause 1 and are not issued to memory.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - The misalignment check is removed; the address is aligned down to 2^size before lane computation and the access proceeds normally.
  - Cause 1 is never reported.
  - Illegal-size and timeout checks remain in both builds.

## Test plan
- XLEN=32, SB addr 0x1003 data 0x000000AB, zero-wait memory -> `mem_be`=4'b1000, `mem_wdata`[31:24]=0xAB, `mem_addr`=0x1000, `resp_valid` at C3, `resp_err`=0.
- LH addr 0x2002, `mem_rdata`=0x8001_1234 -> `resp_rdata`=0xFFFF8001. Same with `req_unsigned`=1 -> 0x00008001.
- `mem_ready` held low 3 cycles, then `mem_rvalid` 2 cycles after the handshake -> `mem_*` stable throughout, exactly one `resp_valid`.
- LW addr 0x3001 -> trap build: cause 1 at C1, `mem_valid` never asserted. Non-trap build: `mem_addr`=0x3000, `mem_be`=4'hF.
- TIMEOUT_CYC=8, memory never ready -> `resp_err`=1, cause 3 at C9. A stray `mem_rvalid` at C12 is ignored and the next request completes correctly.
- `rst` asserted while in WAIT -> IDLE next cycle, no `resp_valid`, `req_ready`=1 after `rst` deasserts.
